// File: rtl/adain_pkg.sv
// Shared AdaIN constants and the normalized-word type passed from the variance
// normalizer to the rsqrt lookup stage.
package adain_pkg;

    localparam int unsigned ADAIN_VAR_W  = 16;
    localparam int unsigned ADAIN_MANT_W = 8;
    localparam int unsigned ADAIN_EXP_W  = $clog2(ADAIN_VAR_W);

    typedef struct packed {
        logic [ADAIN_MANT_W-1:0] mant;
        logic [ADAIN_EXP_W-1:0]  exp;
        logic                    zero;
    } adain_norm_t;

endpackage

// File: rtl/priority_encoder_lin.sv
// Linear leading-one encoder: index of the highest set bit, 0 for an all-zero word.
module priority_encoder_lin #(
    parameter int unsigned WIDTH = 16,
    localparam int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] in_vec,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (in_vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/adain_var_normalizer.sv
// Two-stage valid/ready normalizer: variance word -> (mantissa, exponent, odd, zero).
// Optional half-up rounding of the mantissa when NORM_ROUND_EN is defined.
module adain_var_normalizer
    import adain_pkg::*;
#(
    parameter int unsigned IN_W   = ADAIN_VAR_W,
    parameter int unsigned MANT_W = ADAIN_MANT_W,
    localparam int unsigned EXP_W = $clog2(IN_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [IN_W-1:0]   s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [MANT_W-1:0] m_mant,
    output logic [EXP_W-1:0]  m_exp,
    output logic              m_odd,
    output logic              m_zero
);

    logic              v1_q, v1_d;
    logic [IN_W-1:0]   d1_q, d1_d;
    logic [EXP_W-1:0]  exp1_q, exp1_d;
    logic              zero1_q, zero1_d;
    logic              v2_q, v2_d;
    logic [MANT_W-1:0] mant_q, mant_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic              zero_q, zero_d;

    logic              adv1;
    logic [EXP_W-1:0]  enc_idx;
    logic [EXP_W-1:0]  shamt;
    logic [IN_W-1:0]   norm;
    logic [MANT_W-1:0] mant_trunc;
    logic [MANT_W-1:0] mant_rnd;

    assign adv1    = ~v2_q | m_ready;
    assign s_ready = ~v1_q | adv1;

    priority_encoder_lin #(.WIDTH(IN_W)) u_penc (
        .in_vec (s_data),
        .idx    (enc_idx)
    );

    // IN_W is a power of two, so IN_W-1 fits in EXP_W bits and the shift never overflows.
    assign shamt = EXP_W'(IN_W - 1) - exp1_q;
    assign norm  = d1_q << shamt;

    generate
        if (MANT_W < IN_W) begin : g_split
            logic [IN_W-MANT_W-1:0] tail_unused;
            assign {mant_trunc, tail_unused} = norm;
`ifdef NORM_ROUND_EN
            assign mant_rnd = (tail_unused[IN_W-MANT_W-1] && !(&mant_trunc))
                            ? mant_trunc + MANT_W'(1) : mant_trunc;
`else
            assign mant_rnd = mant_trunc;
`endif
        end else begin : g_full
            assign mant_trunc = norm;
            assign mant_rnd   = mant_trunc;
        end
    endgenerate

    always_comb begin
        v1_d    = v1_q;
        d1_d    = d1_q;
        exp1_d  = exp1_q;
        zero1_d = zero1_q;
        v2_d    = v2_q;
        mant_d  = mant_q;
        exp_d   = exp_q;
        zero_d  = zero_q;

        if (s_ready) begin
            v1_d = s_valid;
            if (s_valid) begin
                d1_d    = s_data;
                exp1_d  = enc_idx;
                zero1_d = (s_data == '0);
            end
        end

        if (adv1) begin
            v2_d = v1_q;
            if (v1_q) begin
                mant_d = zero1_q ? '0 : mant_rnd;
                exp_d  = zero1_q ? '0 : exp1_q;
                zero_d = zero1_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            d1_q    <= '0;
            exp1_q  <= '0;
            zero1_q <= 1'b0;
            v2_q    <= 1'b0;
            mant_q  <= '0;
            exp_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            d1_q    <= d1_d;
            exp1_q  <= exp1_d;
            zero1_q <= zero1_d;
            v2_q    <= v2_d;
            mant_q  <= mant_d;
            exp_q   <= exp_d;
            zero_q  <= zero_d;
        end
    end

    assign m_valid = v2_q;
    assign m_mant  = mant_q;
    assign m_exp   = exp_q;
    assign m_odd   = exp_q[0];
    assign m_zero  = zero_q;

endmodule
